uart_frame_engine: RTL
======================

// Module: uart_frame_engine
// PURPOSE
//  Full-duplex UART frame engine. Successor to the single-frame equipo7 UART.
//  Adds an internal programmable baud prescaler and a parametrised oversample rate.
//  Adds a valid/ready TX handshake, a mid-bit-validated RX start, and an RX FIFO
//  whose entries carry per-frame error flags. Adds an internal loopback mode.
//  Sits between the bus-side register logic and the tx_sn/rx_sn pins.
// PARAMETERS
//  OVERSAMPLE  16  prescaler ticks per bit; even, >=4
//  DIV_W       16  width of baud_div
//  FIFO_DEPTH  4   RX FIFO entries; power of two, >=2
// PORTS
//  clk         in   1      single clock, all logic on rising edge
//  rst_n       in   1      synchronous, active-low reset
//  baud_div    in   DIV_W  tick every baud_div+1 clk cycles (0 => every cycle)
//  cfg         in   5      {stop_sel, parity_en, parity_even, data_len[1:0]}
//  loopback    in   1      1: RX fed from internal TX line; tx_sn held 1
//  tx_data     in   8      frame payload, LSB-aligned
//  tx_valid    in   1      TX request
//  tx_ready    out  1      TX can accept (FSM idle)
//  tx_sn       out  1      serial out, idle high
//  rx_sn       in   1      serial in, asynchronous
//  rx_data     out  8      FIFO head payload, unused upper bits 0
//  rx_valid    out  1      FIFO non-empty
//  rx_ready    in   1      pop FIFO head when rx_valid
//  rx_perr     out  1      head entry parity error
//  rx_ferr     out  1      head entry framing error
//  rx_overrun  out  1      sticky: frame dropped because FIFO full
// BEHAVIOUR
//  Reset values: tx_ready=1, tx_sn=1, rx_valid=0, rx_data=0, rx_perr=0,
//   rx_ferr=0, rx_overrun=0. FIFO is emptied and both FSMs go IDLE.
//   Reset asserted mid-frame aborts the frame immediately.
//  Prescaler: a free-running counter 0..baud_div produces a 1-cycle tick.
//   This tick is shared by TX and RX.
//  Frame format: data bits = 5+data_len. Data is sent LSB first.
//   Even parity: the parity bit equals ^data over the active bits.
//   Odd parity: the parity bit equals ~^data over the active bits.
//   stop_sel=1 selects 2 stop bits on TX. RX checks only the first stop bit.
//  cfg is latched on TX accept and on RX start detect. Mid-frame cfg changes are ignored.
//  TX FSM: IDLE->START->DATA->(PARITY if parity_en)->STOP->IDLE.
//   Accept occurs when tx_valid && tx_ready. tx_ready drops the next cycle.
//   tx_sn goes 0 the cycle after accept.
//   Each bit lasts OVERSAMPLE ticks. The start bit may run up to 1 tick longer.
//   tx_ready returns 1 in the cycle after the last stop tick.
//   tx_valid while busy is ignored, with no queueing.
//  RX path: rx_sn passes through a 2-FF synchroniser, reset to 1.
//   Latency from the pin to the FSM is 2 cycles.
//  RX FSM: IDLE->START->DATA->(PARITY)->STOP->IDLE.
//   IDLE->START: on synced low.
//   START: wait OVERSAMPLE/2 ticks, then resample. If high, it is a false start: go to IDLE, no FIFO write.
//   DATA/PARITY/STOP: sample every OVERSAMPLE ticks at mid-bit.
//   A parity mismatch sets perr. A stop sample of 0 sets ferr.
//   After the stop sample: push {ferr,perr,data} to the FIFO and go to IDLE on the
//    same cycle. This supports back-to-back frames.
//   A frame with errors is still pushed.
//  FIFO: push and pop in the same cycle are allowed in any state, including full.
//   In that case the count is unchanged and the data is preserved in order.
//   Push while full without a pop drops the frame and sets rx_overrun.
//   rx_overrun clears on the next pop.
//   Outputs always reflect the head entry. When empty, rx_data/rx_perr/rx_ferr are 0.
//  Loopback: the RX synchroniser input is the internal TX line. rx_sn is ignored.
// STRUCTURE
//  Package uart_pkg: tx/rx state enums; cfg field index constants;
//   function data_bits(len) = 5+len.
//  Sub-module uart_rx_fifo: sync FIFO, width 10, depth FIFO_DEPTH, with push/pop/full/empty.
//  Prescaler, TX FSM, synchroniser and RX FSM stay in the top module.
// TESTING (OVERSAMPLE=16, baud_div=3 => 64 clk/bit)
//  8N1 send 0xA5 -> tx_sn bits 0,1,0,1,0,0,1,0,1,1, each 64+-4 clk; tx_ready=0 throughout.
//  Loopback 7E1 (cfg=5'b01110) send 0x55 -> rx_valid=1, rx_data=0x55, perr=ferr=0, tx_sn held 1.
//  Drive 8O1 0x01 with parity bit 1 -> rx_data=0x01, rx_perr=1, rx_ferr=0.
//  Drive 8N1 0x3C with stop bit 0 -> rx_data=0x3C, rx_ferr=1.
//  rx_sn low pulse of 5 ticks -> no push, rx_valid stays 0.
//  5 frames 0x10..0x14 without rx_ready -> 4 held, rx_overrun=1. Pops yield 0x10..0x13.
//   rx_overrun clears after the first pop.
//  rst_n=0 mid-TX-data -> next cycle tx_sn=1, tx_ready=1, FIFO empty.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame engine.
// State encodings, cfg field positions, frame width helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // cfg = {stop_sel, parity_en, parity_even, data_len[1:0]}
  localparam int CFG_STOP    = 4;
  localparam int CFG_PEN     = 3;
  localparam int CFG_PEVEN   = 2;
  localparam int CFG_LEN_MSB = 1;
  localparam int CFG_LEN_LSB = 0;

  function automatic logic [3:0] data_bits(
    input logic [1:0] len
  );
    return 4'd5 + {2'b00, len};
  endfunction

  // Keeps only the active payload bits.
  function automatic logic [7:0] data_mask(
    input logic [1:0] len
  );
    return 8'hFF >> (2'd3 - len);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received frames {ferr, perr, data}.
// Ports: push/push_data in, pop in, head/full/empty out.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr, rd;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees the head slot, so a full FIFO may
  // still take a push in the same cycle.
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr && !rd) count_d = count_q + 1'b1;
    if (rd && !wr) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_frame_engine.sv
// Full-duplex UART: baud prescaler, TX/RX FSMs, RX FIFO, loopback.
// Ports: baud_div/cfg setup, tx valid/ready, rx valid/ready + flags.
module uart_frame_engine #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [4:0]       cfg,
  input  logic             loopback,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_sn,
  input  logic             rx_sn,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_perr,
  output logic             rx_ferr,
  output logic             rx_overrun
);
  import uart_pkg::*;

  localparam int unsigned OS_W = $clog2(OVERSAMPLE + 1);
  localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  // Start bit counts one extra tick so it never runs
  // short of a full bit after the prescaler phase.
  localparam logic [OS_W-1:0] OS_START = OS_W'(OVERSAMPLE);

  // prescaler
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  assign tick  = (div_q >= baud_div);
  assign div_d = tick ? '0 : div_q + 1'b1;

  // TX
  tx_state_e       tx_state_q, tx_state_d;
  logic [OS_W-1:0] tx_tcnt_q, tx_tcnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [4:0]      tx_cfg_q, tx_cfg_d;
  logic            tx_par_q, tx_par_d;
  logic [7:0]      tx_masked;
  logic [3:0]      tx_nb;
  logic            tx_line;

  assign tx_masked = tx_data & data_mask(cfg[CFG_LEN_MSB:CFG_LEN_LSB]);
  assign tx_nb     = data_bits(tx_cfg_q[CFG_LEN_MSB:CFG_LEN_LSB]);
  assign tx_ready  = (tx_state_q == TX_IDLE);
  assign tx_sn     = loopback | tx_line;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    tx_cfg_d   = tx_cfg_q;
    tx_par_d   = tx_par_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_state_d = TX_START;
          tx_tcnt_d  = '0;
          tx_bit_d   = '0;
          tx_data_d  = tx_masked;
          tx_cfg_d   = cfg;
          tx_par_d   = cfg[CFG_PEVEN] ? ^tx_masked : ~^tx_masked;
        end
      end
      TX_START: begin
        if (tick) begin
          if (tx_tcnt_q == OS_START) begin
            tx_state_d = TX_DATA;
            tx_tcnt_d  = '0;
          end else begin
            tx_tcnt_d = tx_tcnt_q + 1'b1;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_tcnt_q == OS_LAST) begin
            tx_tcnt_d = '0;
            if ({1'b0, tx_bit_q} == tx_nb - 4'd1) begin
              tx_bit_d   = '0;
              tx_state_d = tx_cfg_q[CFG_PEN] ? TX_PARITY : TX_STOP;
            end else begin
              tx_bit_d = tx_bit_q + 1'b1;
            end
          end else begin
            tx_tcnt_d = tx_tcnt_q + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (tick) begin
          if (tx_tcnt_q == OS_LAST) begin
            tx_tcnt_d  = '0;
            tx_state_d = TX_STOP;
          end else begin
            tx_tcnt_d = tx_tcnt_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        // tx_bit_q counts stop bits here
        if (tick) begin
          if (tx_tcnt_q == OS_LAST) begin
            tx_tcnt_d = '0;
            if (tx_cfg_q[CFG_STOP] && tx_bit_q == 3'd0) begin
              tx_bit_d = 3'd1;
            end else begin
              tx_state_d = TX_IDLE;
            end
          end else begin
            tx_tcnt_d = tx_tcnt_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    unique case (tx_state_q)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_data_q[tx_bit_q];
      TX_PARITY: tx_line = tx_par_q;
      default:   tx_line = 1'b1;
    endcase
  end

  // RX
  rx_state_e       rx_state_q, rx_state_d;
  logic [OS_W-1:0] rx_tcnt_q, rx_tcnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic [3:0]      rx_cfg_q, rx_cfg_d;
  logic            rx_perr_q, rx_perr_d;
  logic [1:0]      sync_q, sync_d;
  logic            rx_s, rx_exp_par;
  logic [3:0]      rx_nb;
  logic            push, pop, full, empty;
  logic [9:0]      push_data, head;
  logic            ovr_q, ovr_d;

  assign sync_d = {sync_q[0], loopback ? tx_line : rx_sn};
  assign rx_s   = sync_q[1];
  assign rx_nb  = data_bits(rx_cfg_q[CFG_LEN_MSB:CFG_LEN_LSB]);
  assign rx_exp_par = rx_cfg_q[CFG_PEVEN] ? ^rx_data_q : ~^rx_data_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_data_d  = rx_data_q;
    rx_cfg_d   = rx_cfg_q;
    rx_perr_d  = rx_perr_q;
    push       = 1'b0;
    push_data  = {~rx_s, rx_perr_q, rx_data_q};
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_d = RX_START;
          rx_tcnt_d  = '0;
          rx_bit_d   = '0;
          rx_data_d  = '0;
          rx_perr_d  = 1'b0;
          rx_cfg_d   = cfg[3:0];
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_tcnt_q == OS_HALF) begin
            rx_tcnt_d  = '0;
            rx_state_d = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_tcnt_d = rx_tcnt_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_tcnt_q == OS_LAST) begin
            rx_tcnt_d = '0;
            rx_data_d[rx_bit_q] = rx_s;
            if ({1'b0, rx_bit_q} == rx_nb - 4'd1) begin
              rx_state_d = rx_cfg_q[CFG_PEN] ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_d = rx_bit_q + 1'b1;
            end
          end else begin
            rx_tcnt_d = rx_tcnt_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (tick) begin
          if (rx_tcnt_q == OS_LAST) begin
            rx_tcnt_d  = '0;
            rx_perr_d  = (rx_s != rx_exp_par);
            rx_state_d = RX_STOP;
          end else begin
            rx_tcnt_d = rx_tcnt_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        // Push at mid stop so a following start edge is caught.
        if (tick) begin
          if (rx_tcnt_q == OS_LAST) begin
            rx_tcnt_d  = '0;
            push       = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_tcnt_d = rx_tcnt_q + 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign pop = rx_ready && !empty;

  always_comb begin
    ovr_d = ovr_q;
    if (pop) ovr_d = 1'b0;
    else if (push && full) ovr_d = 1'b1;
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (10)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign rx_data    = head[7:0];
  assign rx_perr    = head[8];
  assign rx_ferr    = head[9];
  assign rx_valid   = !empty;
  assign rx_overrun = ovr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q      <= '0;
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
      tx_cfg_q   <= '0;
      tx_par_q   <= 1'b0;
      sync_q     <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_cfg_q   <= '0;
      rx_perr_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
      tx_cfg_q   <= tx_cfg_d;
      tx_par_q   <= tx_par_d;
      sync_q     <= sync_d;
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_cfg_q   <= rx_cfg_d;
      rx_perr_q  <= rx_perr_d;
      ovr_q      <= ovr_d;
    end
  end

endmodule
